fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control sequencer for the basic-computer datapath. It runs the fetch, decode and indirect-address cycles (T0–T3) by driving the bus-select lines, the register load strobes, PC increment and memory read of the datapath. It decodes IR into the one-hot opcode D0–D7 and the I bit. It then hands the decoded instruction to the execute stage over a valid/ready handshake and waits before fetching the next word.

## Interface
- No parameters; widths fixed by the 16-bit/4096-word architecture.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; in IDLE, begin fetching at next edge
- halt_req  in  1  level; stop at next instruction boundary
- ir_q  in  16  current IR contents (IR[15]=I, IR[14:12]=opcode, IR[11:0]=address)
- exec_ready  in  1  execute stage done / accepts instruction
- x2  out  1  bus select PC
- x5  out  1  bus select IR
- x7  out  1  bus select memory
- mem_read  out  1  memory read enable
- ld_ar  out  1  AR load strobe
- ld_ir  out  1  IR load strobe
- ld_i  out  1  I flip-flop load strobe
- pc_incr  out  1  PC increment strobe
- t  out  4  one-hot timing T0..T3; 0 in IDLE/EXEC
- d  out  8  one-hot decoded opcode D0..D7, held until next T2
- i_bit  out  1  latched IR[15]
- exec_valid  out  1  decoded instruction ready for execute stage
- running  out  1  high in any state except IDLE
- instr_count  out  16  count of handed-off instructions

## Operation
- States: IDLE, T0, T1, T2, T3, EXEC. Outputs x2/x5/x7/mem_read/ld_*/pc_incr/t/exec_valid are Moore decodes of state. Consumers load on the rising clk edge that ends a cycle in which their strobe is high.
- IDLE: no strobes. start=1 → T0 (halt_req ignored in IDLE).
- T0 (AR←PC): x2, ld_ar. → T1.
- T1 (IR←M[AR], PC←PC+1): mem_read, x7, ld_ir, pc_incr. → T2.
- T2 (decode, AR←IR[11:0], I←IR[15]): x5, ld_ar, ld_i. d ← onehot(ir_q[14:12]) and i_bit ← ir_q[15] registered at end of T2. → T3.
- T3: if d[7]=0 and i_bit=1 (memory-reference, indirect), then AR←M[AR]: mem_read, x7, ld_ar. Otherwise no strobes. → EXEC.
- EXEC: exec_valid=1. Transfer occurs on an edge with exec_valid & exec_ready. On transfer, instr_count increments (wraps FFFF→0000). Next state is IDLE if halt pending, else T0. Without exec_ready, stay in EXEC indefinitely with d/i_bit stable.
- halt pending: set by halt_req=1 sampled in any non-IDLE state. Sticky. Cleared on entering IDLE. A halt never aborts T0–T3 or EXEC.
- start while running: ignored.
- At most one of x2/x5/x7 is high in any cycle.

## Timing
- Reset (asynchronous, immediate): state=IDLE. All strobes, x2/x5/x7, t, d, i_bit, exec_valid, running, halt pending, instr_count = 0.
- Reset mid-instruction aborts with no further strobes. The fetch restarts at T0 only after a new start.
- Latency: start high at edge k → T0 during cycle k+1 → exec_valid first high in cycle k+5. With exec_ready tied high, one instruction takes 5 cycles back-to-back (T0..T3, EXEC).
- d/i_bit valid from the cycle after T2 (T3 onward). They are used by the T3 indirect decision.
- Handshake in the same cycle EXEC is entered is allowed (ready may be combinational-high).

## Test plan
- Reset/idle: rst_n=0 mid-T1 → all outputs 0 asynchronously. Release with start=0 → remains IDLE, running=0.
- Direct fetch: start=1, ir_q=16'h2123 (LDA, I=0), exec_ready=1. Required sequence: T0 {x2,ld_ar}; T1 {mem_read,x7,ld_ir,pc_incr}; T2 {x5,ld_ar,ld_i}; T3 no strobes; EXEC with d=8'b0000_0100, i_bit=0; instr_count=1.
- Indirect: ir_q=16'hA123 → T3 drives {mem_read,x7,ld_ar}, d=8'b0000_0100, i_bit=1.
- Register/IO: ir_q=16'h7800 and 16'hF400 → d=8'h80, no T3 strobes in either case.
- Handshake stall and halt: exec_ready=0 for 10 cycles → EXEC held, d stable, count unchanged. Pulse halt_req during the stall, then exec_ready=1 → count increments and the block goes to IDLE, not T0.
- Wrap: force 65536 back-to-back handoffs (or preload via reset+run) → instr_count 16'hFFFF → 16'h0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode/indirect control sequencer with execute handoff
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic [15:0] ir_q,
  input  logic        exec_ready,
  output logic        x2,
  output logic        x5,
  output logic        x7,
  output logic        mem_read,
  output logic        ld_ar,
  output logic        ld_ir,
  output logic        ld_i,
  output logic        pc_incr,
  output logic [3:0]  t,
  output logic [7:0]  d,
  output logic        i_bit,
  output logic        exec_valid,
  output logic        running,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_EXEC
  } state_t;

  state_t      state;
  logic        halt_pend;
  logic [15:0] cnt_q;
  logic        halt_now;
  logic        indirect_next;

  // The address field goes straight to the datapath; the sequencer never looks at it.
  logic unused_addr;
  assign unused_addr = ^ir_q[11:0];

  // A halt request seen at the handoff edge itself counts as pending.
  assign halt_now = halt_pend | halt_req;

  // T3 indirect decision, evaluated on the IR word being decoded at the end of T2.
  assign indirect_next = ir_q[15] & (ir_q[14:12] != 3'd7);

  assign instr_count = cnt_q;

  // Sequencer: state, registered Moore strobes, decode latches, halt flag and handoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      x2         <= 1'b0;
      x5         <= 1'b0;
      x7         <= 1'b0;
      mem_read   <= 1'b0;
      ld_ar      <= 1'b0;
      ld_ir      <= 1'b0;
      ld_i       <= 1'b0;
      pc_incr    <= 1'b0;
      t          <= 4'd0;
      d          <= 8'd0;
      i_bit      <= 1'b0;
      exec_valid <= 1'b0;
      running    <= 1'b0;
      halt_pend  <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      x2         <= 1'b0;
      x5         <= 1'b0;
      x7         <= 1'b0;
      mem_read   <= 1'b0;
      ld_ar      <= 1'b0;
      ld_ir      <= 1'b0;
      ld_i       <= 1'b0;
      pc_incr    <= 1'b0;
      t          <= 4'd0;
      exec_valid <= 1'b0;

      if (state != S_IDLE && halt_req) begin
        halt_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_T0;
            running <= 1'b1;
            x2      <= 1'b1;
            ld_ar   <= 1'b1;
            t       <= 4'b0001;
          end
        end
        S_T0: begin
          state    <= S_T1;
          mem_read <= 1'b1;
          x7       <= 1'b1;
          ld_ir    <= 1'b1;
          pc_incr  <= 1'b1;
          t        <= 4'b0010;
        end
        S_T1: begin
          state <= S_T2;
          x5    <= 1'b1;
          ld_ar <= 1'b1;
          ld_i  <= 1'b1;
          t     <= 4'b0100;
        end
        S_T2: begin
          state <= S_T3;
          d     <= 8'd1 << ir_q[14:12];
          i_bit <= ir_q[15];
          t     <= 4'b1000;
          if (indirect_next) begin
            mem_read <= 1'b1;
            x7       <= 1'b1;
            ld_ar    <= 1'b1;
          end
        end
        S_T3: begin
          state      <= S_EXEC;
          exec_valid <= 1'b1;
        end
        S_EXEC: begin
          if (exec_ready) begin
            cnt_q <= cnt_q + 16'd1;
            if (halt_now) begin
              state     <= S_IDLE;
              running   <= 1'b0;
              halt_pend <= 1'b0;
            end else begin
              state <= S_T0;
              x2    <= 1'b1;
              ld_ar <= 1'b1;
              t     <= 4'b0001;
            end
          end else begin
            exec_valid <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          running   <= 1'b0;
          halt_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed checks of fetch_sequencer against a cycle model
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [15:0] ir_q;
  logic        exec_ready;
  logic        x2, x5, x7, mem_read, ld_ar, ld_ir, ld_i, pc_incr;
  logic [3:0]  t;
  logic [7:0]  d;
  logic        i_bit, exec_valid, running;
  logic [15:0] instr_count;

  int tests;
  int fails;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .ir_q(ir_q),
    .exec_ready(exec_ready), .x2(x2), .x5(x5), .x7(x7), .mem_read(mem_read),
    .ld_ar(ld_ar), .ld_ir(ld_ir), .ld_i(ld_i), .pc_incr(pc_incr), .t(t), .d(d),
    .i_bit(i_bit), .exec_valid(exec_valid), .running(running), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bundle order: {x2, x5, x7, mem_read, ld_ar, ld_ir, ld_i, pc_incr}
  logic [7:0] strobes;
  assign strobes = {x2, x5, x7, mem_read, ld_ar, ld_ir, ld_i, pc_incr};

  // Behavioural model: phase 0 = idle, 1..4 = T0..T3, 5 = waiting for execute handoff.
  int          m_phase;
  logic [7:0]  m_d;
  logic        m_i;
  logic        m_halt;
  logic [15:0] m_count;

  function automatic logic [7:0] model_strobes(int ph, logic [7:0] dd, logic ii);
    case (ph)
      1: return 8'b1000_1000;
      2: return 8'b0011_0101;
      3: return 8'b0100_1010;
      4: return (!dd[7] && ii) ? 8'b0011_1000 : 8'b0000_0000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_d     = 8'd0;
      m_i     = 1'b0;
      m_halt  = 1'b0;
      m_count = 16'd0;
    end else begin
      int old_ph;
      old_ph = m_phase;
      if (old_ph != 0 && halt_req) m_halt = 1'b1;
      case (old_ph)
        0: if (start) m_phase = 1;
        1: m_phase = 2;
        2: m_phase = 3;
        3: begin
          m_d = 8'd0;
          m_d[ir_q[14:12]] = 1'b1;
          m_i = ir_q[15];
          m_phase = 4;
        end
        4: m_phase = 5;
        default: if (exec_ready) begin
          m_count = m_count + 16'd1;
          m_phase = m_halt ? 0 : 1;
        end
      endcase
      if (m_phase == 0) m_halt = 1'b0;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Every cycle: compare all outputs with the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] exp_t;
    exp_t = (m_phase >= 1 && m_phase <= 4) ? (4'b0001 << (m_phase - 1)) : 4'b0000;
    check("m_strobes", {24'd0, strobes}, {24'd0, model_strobes(m_phase, m_d, m_i)});
    check("m_t", {28'd0, t}, {28'd0, exp_t});
    check("m_d_i", {23'd0, d, i_bit}, {23'd0, m_d, m_i});
    check("m_valid_run", {30'd0, exec_valid, running}, {30'd0, (m_phase == 5), (m_phase != 0)});
    check("m_count", {16'd0, instr_count}, {16'd0, m_count});
  end

  task automatic run_one(logic [15:0] ir, logic [7:0] exp_t3, logic [7:0] exp_d,
                         logic exp_i, logic [15:0] exp_cnt);
    @(negedge clk);
    start = 1'b1; ir_q = ir; exec_ready = 1'b1; halt_req = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("t0_strobes", {24'd0, strobes}, 32'h88);
    check("t0_t", {28'd0, t}, 32'h1);
    @(negedge clk);
    check("t1_strobes", {24'd0, strobes}, 32'h35);
    @(negedge clk);
    check("t2_strobes", {24'd0, strobes}, 32'h4A);
    @(negedge clk);
    check("t3_strobes", {24'd0, strobes}, {24'd0, exp_t3});
    check("t3_d", {24'd0, d}, {24'd0, exp_d});
    check("t3_i", {31'd0, i_bit}, {31'd0, exp_i});
    @(negedge clk);
    check("exec_valid", {31'd0, exec_valid}, 32'h1);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("halt_idle", {31'd0, running}, 32'h0);
    check("count", {16'd0, instr_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; ir_q = 16'h0; exec_ready = 1'b0;
    #1;
    check("reset_all", {strobes, t, d, i_bit, exec_valid, running, 1'b0},
          32'h0);
    check("reset_count", {16'd0, instr_count}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed fetches: direct, indirect, register-reference, I/O.
    run_one(16'h2123, 8'h00, 8'b0000_0100, 1'b0, 16'd1);
    run_one(16'hA123, 8'h38, 8'b0000_0100, 1'b1, 16'd2);
    run_one(16'h7800, 8'h00, 8'h80, 1'b0, 16'd3);
    run_one(16'hF400, 8'h00, 8'h80, 1'b1, 16'd4);

    // Handshake stall with a halt pulse in the middle.
    @(negedge clk);
    start = 1'b1; ir_q = 16'h3456; exec_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!exec_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("stall_reach_exec", {31'd0, exec_valid}, 32'h1);
    end
    for (int c = 0; c < 10; c++) begin
      halt_req = (c == 3);
      @(negedge clk);
      check("stall_valid", {31'd0, exec_valid}, 32'h1);
      check("stall_d", {24'd0, d}, 32'h08);
      check("stall_count", {16'd0, instr_count}, 32'd4);
    end
    halt_req = 1'b0;
    exec_ready = 1'b1;
    @(negedge clk);
    check("stall_halt_idle", {28'd0, running, t[0], x2, exec_valid}, 32'h0);
    check("stall_count_after", {16'd0, instr_count}, 32'd5);

    // Asynchronous reset in the middle of T1, then release without start.
    @(negedge clk);
    start = 1'b1; exec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_t1", {28'd0, t}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {strobes, t, d, i_bit, exec_valid, running, 1'b0}, 32'h0);
    check("async_reset_cnt", {16'd0, instr_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {31'd0, running}, 32'h0);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      rst_n      = ($urandom_range(0, 299) != 0);
      start      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 15) == 0);
      exec_ready = ($urandom_range(0, 2) != 0);
      ir_q       = 16'($urandom);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Counter wrap: preload near the top while idle, then two handoffs.
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    m_count = 16'hFFFE;
    @(posedge clk);
    #1 release dut.cnt_q;
    run_one(16'h1001, 8'h00, 8'h02, 1'b0, 16'hFFFF);
    run_one(16'h9001, 8'h38, 8'h02, 1'b1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
